// File: rtl/opto_pulse_emulator.sv
// Synthetic slotted code-wheel pulse source: TOOTH_NUM teeth with one missing tooth
// as the index mark, plus optional programmable glitches inside each HIGH phase.
module opto_pulse_emulator #(
  parameter int unsigned TOOTH_NUM = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [15:0] i_half_period,
  input  logic        i_glitch_en,
  input  logic [7:0]  i_glitch_width,
  output logic        o_opto_switch,
  output logic        o_rev_pulse,
  output logic [7:0]  o_tooth_idx,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  localparam logic [7:0] LAST_TOOTH = 8'(TOOTH_NUM - 1);

  state_e      state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic [15:0] heff_q, heff_d;
  logic [7:0]  tooth_q, tooth_d;
  logic        opto_q, opto_d;
  logic        rev_q, rev_d;
  logic        busy_q, busy_d;

  logic [15:0] h_clamp;
  logic [17:0] heff_ext;
  logic [17:0] low_len;
  logic [17:0] cnt_nxt;
  logic [16:0] g_start;
  logic [16:0] g_end;
  logic        last_tooth;
  logic        in_glitch;

  always_comb begin
    h_clamp    = (i_half_period < 16'd2) ? 16'd2 : i_half_period;
    heff_ext   = {2'b00, heff_q};
    last_tooth = (tooth_q == LAST_TOOTH);
    // missing tooth: LOW stretched to 3*H_eff
    low_len    = last_tooth ? (heff_ext + {1'b0, heff_q, 1'b0}) : heff_ext;
    cnt_nxt    = cnt_q + 18'd1;
    g_start    = {2'b00, heff_q[15:1]};
    g_end      = g_start + {9'd0, i_glitch_width};
    // opto is registered, so the glitch test looks at the counter value of the next cycle
    in_glitch  = i_glitch_en && (i_glitch_width != 8'd0) &&
                 (cnt_nxt >= {1'b0, g_start}) && (cnt_nxt < {1'b0, g_end});

    state_d = IDLE;
    cnt_d   = '0;
    heff_d  = 16'd2;
    tooth_d = '0;
    opto_d  = 1'b0;
    rev_d   = 1'b0;
    busy_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d = HIGH;
          heff_d  = h_clamp;
          opto_d  = 1'b1;
          rev_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      HIGH: begin
        if (i_enable) begin
          busy_d  = 1'b1;
          heff_d  = heff_q;
          tooth_d = tooth_q;
          if (cnt_q == heff_ext - 18'd1) begin
            state_d = LOW;
          end else begin
            state_d = HIGH;
            cnt_d   = cnt_nxt;
            opto_d  = !in_glitch;
          end
        end
      end
      LOW: begin
        if (i_enable) begin
          busy_d = 1'b1;
          if (cnt_q == low_len - 18'd1) begin
            state_d = HIGH;
            heff_d  = h_clamp;
            tooth_d = last_tooth ? 8'd0 : tooth_q + 8'd1;
            opto_d  = 1'b1;
            rev_d   = last_tooth;
          end else begin
            state_d = LOW;
            cnt_d   = cnt_nxt;
            heff_d  = heff_q;
            tooth_d = tooth_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      heff_q  <= 16'd2;
      tooth_q <= '0;
      opto_q  <= 1'b0;
      rev_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      heff_q  <= heff_d;
      tooth_q <= tooth_d;
      opto_q  <= opto_d;
      rev_q   <= rev_d;
      busy_q  <= busy_d;
    end
  end

  assign o_opto_switch = opto_q;
  assign o_rev_pulse   = rev_q;
  assign o_tooth_idx   = tooth_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_opto_pulse_emulator.sv
// Self-checking bench for opto_pulse_emulator (TOOTH_NUM=4) against a tooth-position
// reference model: position t runs 0..period-1 across the whole tooth.
module tb_opto_pulse_emulator;

  localparam int unsigned N = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [15:0] i_half_period = 16'd10;
  logic        i_glitch_en = 1'b0;
  logic [7:0]  i_glitch_width = 8'd0;
  logic        o_opto_switch;
  logic        o_rev_pulse;
  logic [7:0]  o_tooth_idx;
  logic        o_busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // reference model state
  bit          m_run = 0;
  int unsigned m_tooth = 0;
  int unsigned m_t = 0;
  int unsigned m_heff = 2;
  bit          m_rev = 0;
  bit          m_gen = 0;
  int unsigned m_w = 0;

  opto_pulse_emulator #(.TOOTH_NUM(N)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .i_half_period  (i_half_period),
    .i_glitch_en    (i_glitch_en),
    .i_glitch_width (i_glitch_width),
    .o_opto_switch  (o_opto_switch),
    .o_rev_pulse    (o_rev_pulse),
    .o_tooth_idx    (o_tooth_idx),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic int unsigned clamp_h(input int unsigned h);
    return (h < 2) ? 2 : h;
  endfunction

  function automatic bit exp_opto();
    int unsigned gs;
    if (!m_run) return 0;
    if (m_t >= m_heff) return 0;
    gs = m_heff / 2;
    if (m_gen && m_w != 0 && m_t >= gs && m_t < gs + m_w) return 0;
    return 1;
  endfunction

  task automatic chk(input string tag, input int unsigned obs, input int unsigned expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("opto",  32'(o_opto_switch), 32'(exp_opto()));
    chk("rev",   32'(o_rev_pulse),   32'(m_rev));
    chk("tooth", 32'(o_tooth_idx),   m_run ? m_tooth : 0);
    chk("busy",  32'(o_busy),        32'(m_run));
  endtask

  // one clock: inputs are stable across the edge, model advances, outputs compared 1 after
  task automatic step();
    bit en, rst;
    int unsigned h, period;
    en = i_enable;
    rst = i_rst_n;
    h = 32'(i_half_period);
    @(posedge i_clk);
    m_gen = i_glitch_en;
    m_w = 32'(i_glitch_width);
    m_rev = 0;
    if (!rst || !en) begin
      m_run = 0;
      if (!rst) m_run = 0;
    end else if (!m_run) begin
      m_run = 1;
      m_tooth = 0;
      m_t = 0;
      m_heff = clamp_h(h);
      m_rev = 1;
    end else begin
      period = (m_tooth == N - 1) ? 4 * m_heff : 2 * m_heff;
      m_t++;
      if (m_t == period) begin
        m_t = 0;
        m_tooth = (m_tooth + 1) % N;
        m_heff = clamp_h(h);
        m_rev = (m_tooth == 0);
      end
    end
    #1;
    check_all();
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    // reset state
    run(3);
    i_rst_n = 1'b1;
    run(2);

    // H=10 then H=20 during tooth 1 HIGH; full revolutions with the missing tooth
    i_half_period = 16'd10;
    i_enable = 1'b1;
    run(25);
    i_half_period = 16'd20;
    run(260);

    // clamping of H=0 and H=1
    i_enable = 1'b0;
    run(2);
    i_half_period = 16'd0;
    i_enable = 1'b1;
    run(40);
    i_half_period = 16'd1;
    run(40);

    // glitch truncated at end of HIGH
    i_enable = 1'b0;
    run(1);
    i_half_period = 16'd8;
    i_glitch_en = 1'b1;
    i_glitch_width = 8'd10;
    i_enable = 1'b1;
    run(80);

    // long phases with a 100-cycle glitch
    i_enable = 1'b0;
    run(1);
    i_half_period = 16'd1000;
    i_glitch_width = 8'd100;
    i_enable = 1'b1;
    run(10100);

    // disable mid-HIGH of tooth 2, then re-enable
    i_enable = 1'b0;
    i_glitch_en = 1'b0;
    run(1);
    i_half_period = 16'd10;
    i_enable = 1'b1;
    run(45);
    i_enable = 1'b0;
    run(1);
    i_enable = 1'b1;
    run(55);

    // async reset mid-LOW of tooth 2, outputs drop without a clock edge
    #2;
    i_rst_n = 1'b0;
    #1;
    m_run = 0;
    m_rev = 0;
    check_all();
    run(2);
    i_enable = 1'b0;
    #2;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    run(5);
    i_enable = 1'b1;
    run(30);

    // randomized segments
    for (int k = 0; k < 40; k++) begin
      i_half_period  = 16'($urandom_range(0, 12));
      i_glitch_en    = 1'($urandom_range(0, 1));
      i_glitch_width = 8'($urandom_range(0, 15));
      i_enable       = ($urandom_range(0, 4) != 0);
      run($urandom_range(1, 60));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
